// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store initiator and dmem_responder.
//   req_*  : initiator -> responder request channel (valid/ready handshake)
//   rsp_*  : responder -> initiator response channel (valid/ready handshake)
// master modport = initiator side, slave modport = responder side.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_width;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_width, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_width, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Byte-addressed little-endian data memory with a single outstanding
// request and a programmable response latency.
// Ports:
//   clk    : clock, all state updates on rising edge
//   rst_n  : asynchronous active-low reset (memory contents untouched)
//   bus    : dmem_responder_if.slave (req_valid/ready/write/addr/wdata/width,
//            rsp_valid/ready/rdata/err)
// Parameters:
//   DEPTH_BYTES : memory size in bytes, power of two, 4..65536
//   WAIT_CYCLES : extra response latency, 0..15
// Build option:
//   DMEM_RESP_ERR_EN defined   -> misaligned, out-of-range and illegal-width
//                                 requests answer rsp_err=1 with no side effect
//   DMEM_RESP_ERR_EN undefined -> rsp_err=0, address aligned down to the
//                                 access size, wraps modulo DEPTH_BYTES,
//                                 illegal widths act as word accesses
module dmem_responder #(
  parameter int unsigned DEPTH_BYTES = 4096,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic             clk,
  input logic             rst_n,
  dmem_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  width;
  } op_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  op_t             op_q, op_c;
  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;

  logic            accept_c;
  logic            enter_resp_c;
  logic            bad_width_c;
  logic            err_c;
  logic            we_c;
  logic [2:0]      size_c;
  logic [AW-1:0]   idx_c;
  logic [7:0]      b0_c, b1_c, b2_c, b3_c;
  logic [31:0]     load_c;

  logic [7:0]      mem [DEPTH_BYTES];

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  assign accept_c = bus.req_valid & req_ready_q;

  // Operation being executed: the live bus on the accept edge (needed when
  // WAIT_CYCLES=0 commits on that same edge), the latched copy afterwards.
  always_comb begin
    op_c = op_q;
    if (state_q == S_IDLE) begin
      op_c.write = bus.req_write;
      op_c.addr  = bus.req_addr;
      op_c.wdata = bus.req_wdata;
      op_c.width = bus.req_width;
    end
  end

  // Access size in bytes; illegal encodings flagged and sized as a word.
  always_comb begin
    size_c      = 3'd4;
    bad_width_c = 1'b0;
    case (op_c.width)
      3'b000, 3'b100: size_c = 3'd1;
      3'b001, 3'b101: size_c = 3'd2;
      3'b010:         size_c = 3'd4;
      default:        bad_width_c = 1'b1;
    endcase
  end

`ifdef DMEM_RESP_ERR_EN
  assign err_c = bad_width_c
               | ((size_c == 3'd2) & op_c.addr[0])
               | ((size_c == 3'd4) & (|op_c.addr[1:0]))
               | ((33'(op_c.addr) + 33'(size_c)) > 33'(DEPTH_BYTES));
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^{op_c.addr[31:AW], bad_width_c};
  assign err_c = 1'b0;
`endif

  // Byte index aligned down to the access size; a no-op for legal error-free
  // requests, and the alignment/wrap rule when error detection is off.
  always_comb begin
    idx_c = op_c.addr[AW-1:0];
    if (size_c == 3'd2) idx_c[0] = 1'b0;
    if (size_c == 3'd4) idx_c[1:0] = 2'b00;
  end

  assign b0_c = mem[idx_c];
  assign b1_c = mem[idx_c + AW'(1)];
  assign b2_c = mem[idx_c + AW'(2)];
  assign b3_c = mem[idx_c + AW'(3)];

  // Load data extension.
  always_comb begin
    case (op_c.width)
      3'b000:  load_c = {{24{b0_c[7]}}, b0_c};
      3'b100:  load_c = {24'h0, b0_c};
      3'b001:  load_c = {{16{b1_c[7]}}, b1_c, b0_c};
      3'b101:  load_c = {16'h0, b1_c, b0_c};
      default: load_c = {b3_c, b2_c, b1_c, b0_c};
    endcase
  end

  // Next state and registered outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    enter_resp_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (WAIT_CYCLES == 0) begin
            state_d      = S_RESP;
            enter_resp_c = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CW'(WAIT_CYCLES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d      = S_RESP;
          enter_resp_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    if (enter_resp_c) begin
      rsp_err_d   = err_c;
      rsp_rdata_d = (op_c.write | err_c) ? 32'h0 : load_c;
    end else if (state_d != S_RESP) begin
      rsp_err_d   = 1'b0;
      rsp_rdata_d = 32'h0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      if (accept_c) op_q <= op_c;
    end
  end

  // Store commit on the edge entering RESP; rst_n gating keeps an edge seen
  // while in reset from writing.
  assign we_c = enter_resp_c & op_c.write & ~err_c & rst_n;

  always_ff @(posedge clk) begin
    if (we_c) begin
      mem[idx_c] <= op_c.wdata[7:0];
      if (size_c != 3'd1) mem[idx_c + AW'(1)] <= op_c.wdata[15:8];
      if (size_c == 3'd4) begin
        mem[idx_c + AW'(2)] <= op_c.wdata[23:16];
        mem[idx_c + AW'(3)] <= op_c.wdata[31:24];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, reset
// corner sequences on a WAIT_CYCLES=3 instance, and randomized traffic
// against a byte-array reference model. Honors DMEM_RESP_ERR_EN.
module tb_dmem_responder;

  localparam int DEPTH = 4096;
`ifdef DMEM_RESP_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, rst_n3;
  always #5 clk = ~clk;

  // Shared drive signals, steered to one DUT by sel.
  logic        sel;
  logic        req_valid, req_write, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_width;

  dmem_responder_if bus ();
  dmem_responder_if bus3 ();

  assign bus.req_valid  = req_valid & ~sel;
  assign bus.rsp_ready  = rsp_ready & ~sel;
  assign bus.req_write  = req_write;
  assign bus.req_addr   = req_addr;
  assign bus.req_wdata  = req_wdata;
  assign bus.req_width  = req_width;
  assign bus3.req_valid = req_valid & sel;
  assign bus3.rsp_ready = rsp_ready & sel;
  assign bus3.req_write = req_write;
  assign bus3.req_addr  = req_addr;
  assign bus3.req_wdata = req_wdata;
  assign bus3.req_width = req_width;

  logic        m_req_ready, m_rsp_valid, m_rsp_err;
  logic [31:0] m_rsp_rdata;
  assign m_req_ready = sel ? bus3.req_ready : bus.req_ready;
  assign m_rsp_valid = sel ? bus3.rsp_valid : bus.rsp_valid;
  assign m_rsp_err   = sel ? bus3.rsp_err   : bus.rsp_err;
  assign m_rsp_rdata = sel ? bus3.rsp_rdata : bus.rsp_rdata;

  dmem_responder #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  dmem_responder #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n3), .bus(bus3)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%h want 0x%h", nm, act, exp);
    end
  endtask

  // Reference memory: plain byte array, rules applied directly.
  logic [7:0] mm [DEPTH];

  task automatic model(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] w, output logic [31:0] rd, output logic er);
    int     size;
    bit     bad_w, sgn;
    int     ea;
    longint v;
    bad_w = 1'b0;
    sgn   = 1'b0;
    size  = 4;
    case (w)
      3'd0: begin size = 1; sgn = 1'b1; end
      3'd4: size = 1;
      3'd1: begin size = 2; sgn = 1'b1; end
      3'd5: size = 2;
      3'd2: size = 4;
      default: bad_w = 1'b1;
    endcase
    er = ERR && (bad_w || (longint'(a) % size != 0) || (longint'(a) + size > DEPTH));
    ea = int'((longint'(a) / size * size) % DEPTH);
    rd = '0;
    if (!er) begin
      if (wr) begin
        for (int i = 0; i < size; i++) mm[ea + i] = d[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < size; i++) v = v | (longint'(mm[ea + i]) << (8 * i));
        if (sgn && v[8*size-1]) v = v - (longint'(1) << (8 * size));
        rd = 32'(v);
      end
    end
  endtask

  // One full transaction on the selected DUT. Called and returns at a negedge.
  task automatic xact(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] w, input int hold, input int exp_lat,
                      output logic [31:0] rd, output logic er);
    int lat;
    chk("ready_before_req", 32'(m_req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_width = w;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = ~wr;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_width = 3'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!m_rsp_valid) chk("ready_low_wait", 32'(m_req_ready), 32'd0);
    end while (!m_rsp_valid && lat < 40);
    chk("latency", 32'(lat), 32'(exp_lat));
    rd = m_rsp_rdata;
    er = m_rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(m_rsp_valid), 32'd1);
      chk("hold_rdata", m_rsp_rdata, rd);
      chk("hold_err", 32'(m_rsp_err), 32'(er));
      chk("hold_ready_low", 32'(m_req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(m_req_ready), 32'd1);
    chk("idle_valid", 32'(m_rsp_valid), 32'd0);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  w;
    int          hold;
    logic        er;
    logic [31:0] rd;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] w, input int hold, input logic er, input logic [31:0] rd);
    vt.push_back('{wr, a, d, w, hold, er, rd});
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, mrd, a;
    logic        er, mer, wr;
    logic [2:0]  w;

    sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; rsp_ready = 1'b0;
    req_addr = '0; req_wdata = '0; req_width = '0;
    rst_n = 1'b0; rst_n3 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(m_rsp_valid), 32'd0);
    chk("rst_rdata", m_rsp_rdata, 32'd0);
    chk("rst_err", 32'(m_rsp_err), 32'd0);
    rst_n = 1'b1; rst_n3 = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(m_req_ready), 32'd1);
    chk("rel_valid", 32'(m_rsp_valid), 32'd0);

    // Directed table on the WAIT_CYCLES=2 instance.
    add(1, 32'h000, 32'hCAFEF00D, 3'd2, 0, 0, 32'h0);
    add(1, 32'hFFC, 32'h55667788, 3'd2, 0, 0, 32'h0);
    add(1, 32'h010, 32'h800000FF, 3'd2, 0, 0, 32'h0);
    add(0, 32'h010, 32'h0, 3'd0, 0, 0, 32'hFFFFFFFF);
    add(0, 32'h010, 32'h0, 3'd4, 0, 0, 32'h000000FF);
    add(0, 32'h010, 32'h0, 3'd1, 0, 0, 32'h000000FF);
    add(0, 32'h012, 32'h0, 3'd5, 0, 0, 32'h00008000);
    add(0, 32'h012, 32'h0, 3'd1, 5, 0, 32'hFFFF8000);
    add(0, 32'h010, 32'h0, 3'd2, 0, 0, 32'h800000FF);
    add(1, 32'h020, 32'h11223344, 3'd2, 0, 0, 32'h0);
    add(1, 32'h022, 32'h1234BEEF, 3'd1, 0, 0, 32'h0);
    add(0, 32'h020, 32'h0, 3'd2, 0, 0, 32'hBEEF3344);
    add(1, 32'h021, 32'hFFFFFF5A, 3'd0, 0, 0, 32'h0);
    add(0, 32'h020, 32'h0, 3'd2, 3, 0, 32'hBEEF5A44);
    add(0, 32'h021, 32'h0, 3'd2, 0, ERR, ERR ? 32'h0 : 32'hBEEF5A44);
    add(0, 32'h1000, 32'h0, 3'd2, 0, ERR, ERR ? 32'h0 : 32'hCAFEF00D);
    add(0, 32'h1003, 32'h0, 3'd2, 0, ERR, ERR ? 32'h0 : 32'hCAFEF00D);
    add(0, 32'hFFE, 32'h0, 3'd1, 0, 0, 32'h00005566);
    add(0, 32'hFFE, 32'h0, 3'd5, 0, 0, 32'h00005566);
    add(0, 32'hFFF, 32'h0, 3'd0, 0, 0, 32'h00000055);
    add(0, 32'hFFF, 32'h0, 3'd1, 0, ERR, ERR ? 32'h0 : 32'h00005566);
    add(0, 32'hFFF, 32'h0, 3'd2, 0, ERR, ERR ? 32'h0 : 32'h55667788);
    add(0, 32'h023, 32'h0, 3'd5, 0, ERR, ERR ? 32'h0 : 32'h0000BEEF);
    add(0, 32'h020, 32'h0, 3'd3, 0, ERR, ERR ? 32'h0 : 32'hBEEF5A44);
    add(1, 32'h1002, 32'h00000001, 3'd2, 0, ERR, 32'h0);
    add(0, 32'h000, 32'h0, 3'd2, 0, 0, ERR ? 32'hCAFEF00D : 32'h00000001);
    add(1, 32'h010, 32'h00000099, 3'd7, 0, ERR, 32'h0);
    add(0, 32'h010, 32'h0, 3'd2, 0, 0, ERR ? 32'h800000FF : 32'h00000099);
    add(0, 32'hFFFFFFFC, 32'h0, 3'd2, 0, ERR, ERR ? 32'h0 : 32'h55667788);

    for (int i = 0; i < vt.size(); i++) begin
      xact(vt[i].wr, vt[i].a, vt[i].d, vt[i].w, vt[i].hold, 3, rd, er);
      model(vt[i].wr, vt[i].a, vt[i].d, vt[i].w, mrd, mer);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].rd);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].er));
    end

    // WAIT_CYCLES=3 instance: reset in RESP clears outputs at once.
    sel = 1'b1;
    xact(1'b1, 32'h40, 32'h12345678, 3'd2, 0, 4, rd, er);
    chk("d3_store_rdata", rd, 32'h0);
    chk("d3_store_err", 32'(er), 32'd0);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40; req_width = 3'd2; rsp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("d3_resp_valid", 32'(m_rsp_valid), 32'd1);
    chk("d3_resp_rdata", m_rsp_rdata, 32'h12345678);
    rst_n3 = 1'b0;
    #1;
    chk("d3_rst_valid", 32'(m_rsp_valid), 32'd0);
    chk("d3_rst_rdata", m_rsp_rdata, 32'h0);
    chk("d3_rst_err", 32'(m_rsp_err), 32'd0);
    @(negedge clk);
    rst_n3 = 1'b1;
    @(negedge clk);
    chk("d3_rel_ready", 32'(m_req_ready), 32'd1);

    // Reset one cycle after a store is accepted aborts the store.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'hAAAAAAAA;
    req_width = 3'd2;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2 rst_n3 = 1'b0;
    #1;
    chk("d3_abort_valid", 32'(m_rsp_valid), 32'd0);
    chk("d3_abort_rdata", m_rsp_rdata, 32'h0);
    chk("d3_abort_err", 32'(m_rsp_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n3 = 1'b1;
    repeat (3) @(negedge clk);
    chk("d3_abort_ready", 32'(m_req_ready), 32'd1);
    chk("d3_abort_idle", 32'(m_rsp_valid), 32'd0);
    xact(1'b0, 32'h40, 32'h0, 3'd2, 0, 4, rd, er);
    chk("d3_prior_value", rd, 32'h12345678);
    chk("d3_prior_err", 32'(er), 32'd0);
    sel = 1'b0;

    // Fill the random address windows so every later load is defined.
    for (int base = 0; base < 2; base++) begin
      for (int off = 0; off < 64; off += 4) begin
        a = (base == 0) ? 32'(off) : 32'(32'hFC0 + off);
        xact(1'b1, a, $urandom, 3'd2, 0, 3, rd, er);
        model(1'b1, a, 32'h0, 3'd2, mrd, mer);
        chk("fill_err", 32'(er), 32'(mer));
      end
    end
    // model() stored zeros above; resync model bytes from loads below instead
    // would need readback, so redo fill with known data in the model too.
    for (int base = 0; base < 2; base++) begin
      for (int off = 0; off < 64; off += 4) begin
        logic [31:0] dv;
        dv = $urandom;
        a = (base == 0) ? 32'(off) : 32'(32'hFC0 + off);
        xact(1'b1, a, dv, 3'd2, 0, 3, rd, er);
        model(1'b1, a, dv, 3'd2, mrd, mer);
        chk("fill2_rdata", rd, mrd);
      end
    end

    // Reset while idle leaves memory intact.
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(m_rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] dv;
      case ($urandom_range(0, 3))
        0:       a = 32'h0;
        1:       a = 32'hFC0;
        2:       a = 32'h1000;
        default: a = 32'hFFFFFFC0;
      endcase
      a  = a + 32'($urandom_range(0, 63));
      wr = 1'($urandom);
      w  = 3'($urandom);
      dv = $urandom;
      xact(wr, a, dv, w, $urandom_range(0, 2), 3, rd, er);
      model(wr, a, dv, w, mrd, mer);
      chk($sformatf("rnd%0d_rdata a=%h w=%0d wr=%0d", n, a, w, wr), rd, mrd);
      chk($sformatf("rnd%0d_err a=%h w=%0d wr=%0d", n, a, w, wr), 32'(er), 32'(mer));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_BYTES, default 4096, data memory size in bytes; SHALL be a power of two, 4..65536.
REQ-002 Parameter WAIT_CYCLES, default 1, added response latency in cycles; SHALL be 0..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_write  input  1  1=store, 0=load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 req_width  input  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  initiator accepts response.
REQ-013 rsp_rdata  output  32  load data, extended to 32 bits; 0 for stores and errors.
REQ-014 rsp_err  output  1  request rejected; no memory side effect.

Function
REQ-015 FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in RESP.
REQ-016 Request accepted on edge with req_valid && req_ready; addr, wdata, width, write SHALL be latched; later input changes ignored.
REQ-017 On accept: WAIT_CYCLES=0 -> RESP; else -> WAIT with counter = WAIT_CYCLES-1.
REQ-018 WAIT: counter decrements each cycle; at 0 -> RESP next edge; rsp_valid first high exactly WAIT_CYCLES+1 cycles after accept edge.
REQ-019 Store commit and load capture SHALL occur on the edge entering RESP, never earlier.
REQ-020 RESP: rsp_rdata/rsp_err SHALL be held stable until rsp_valid && rsp_ready; on that edge -> IDLE; no back-to-back accept on the same edge.
REQ-021 Memory byte-addressed, little-endian; B/H/W write 1/2/4 bytes at addr, other bytes unchanged.
REQ-022 Loads: B/H sign-extend, BU/HU zero-extend, W unmodified.
REQ-023 Error conditions: H/HU with addr[0]=1; W with addr[1:0]!=0; addr+size > DEPTH_BYTES; width 011/110/111.
REQ-024 On error: rsp_err=1, rsp_rdata=0, memory unchanged, same latency and handshake as a good request.
REQ-025 Store response: rsp_rdata=0, rsp_err=0.
REQ-026 Memory contents at power-up undefined; not initialised by any input.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1 once released.
REQ-028 Reset during WAIT SHALL abort the request; an uncommitted store SHALL NOT be written.
REQ-029 Reset SHALL NOT alter memory contents.

Configuration
REQ-030 Macro DMEM_RESP_ERR_EN defined: error detection per REQ-023/024.
REQ-031 Macro undefined: rsp_err tied 0; address low bits masked to width alignment; address wraps modulo DEPTH_BYTES; invalid widths behave as W.

Verification
REQ-032 WAIT_CYCLES=2: SW 0x8000_00FF to 0x10, then LB 0x10 -> rsp_valid 3 cycles after each accept, load rsp_rdata=0xFFFF_FFFF, LBU 0x10 -> 0x0000_00FF.
REQ-033 SH 0xBEEF to 0x22 over word 0x1122_3344 at 0x20 -> LW 0x20 returns 0xBEEF_3344.
REQ-034 ERR_EN defined: LW 0x21 and LW 0x1000 (DEPTH 4096) -> rsp_err=1, rsp_rdata=0; SW 0x0000_0001 to 0x1002 -> memory unchanged.
REQ-035 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid, rsp_rdata stable, req_ready=0 throughout; IDLE one cycle after rsp_ready=1.
REQ-036 rst_n pulsed low one cycle after SW 0xAAAA_AAAA to 0x40 accepted (WAIT_CYCLES=3) -> outputs 0 immediately, subsequent LW 0x40 returns prior value.
REQ-037 ERR_EN undefined: LW 0x1003 -> rsp_err=0, returns word at 0x0000.
